// File: rtl/sipo_frame_rx.sv
// sipo_frame_rx: reassembles MSB-first serial frames into WIDTH-bit words
// behind a registered valid/ready output with a sticky overrun flag.
module sipo_frame_rx #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin,
    input  logic             en,
    input  logic             start,
    input  logic             pready,
    output logic [WIDTH-1:0] pout,
    output logic             pvalid,
    output logic             busy,
    output logic             ovf
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] pout_q, pout_d;
    logic             pvalid_q, pvalid_d;
    logic             ovf_q, ovf_d;
    logic             done;
    logic [WIDTH-1:0] word;

    assign word = {shift_q[WIDTH-2:0], sin};

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        cnt_d    = cnt_q;
        pout_d   = pout_q;
        pvalid_d = pvalid_q & ~pready;
        ovf_d    = ovf_q;
        done     = 1'b0;
        // start wins over completion, so a marker always begins a fresh frame
        if (en && start) begin
            shift_d = {{(WIDTH-1){1'b0}}, sin};
            cnt_d   = CW'(1);
            state_d = SHIFT;
        end else if (en && state_q == SHIFT) begin
            shift_d = word;
            done    = (cnt_q == CW'(WIDTH - 1));
            cnt_d   = done ? '0 : cnt_q + 1'b1;
            state_d = done ? IDLE : SHIFT;
        end
        if (done) begin
            if (!pvalid_q || pready) begin
                pout_d   = word;
                pvalid_d = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            cnt_q    <= '0;
            pout_q   <= '0;
            pvalid_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            cnt_q    <= cnt_d;
            pout_q   <= pout_d;
            pvalid_q <= pvalid_d;
            ovf_q    <= ovf_d;
        end
    end

    assign pout   = pout_q;
    assign pvalid = pvalid_q;
    assign busy   = (state_q == SHIFT);
    assign ovf    = ovf_q;
endmodule

// File: tb/tb_sipo_frame_rx.sv
// tb_sipo_frame_rx: directed checks of framing, handshake and overrun behaviour.
module tb_sipo_frame_rx;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sin = 1'b0;
    logic       en = 1'b0;
    logic       start = 1'b0;
    logic       pready = 1'b0;
    logic [3:0] pout;
    logic       pvalid, busy, ovf;
    int         n_cmp = 0;
    int         n_bad = 0;

    sipo_frame_rx #(.WIDTH(4)) dut (
        .clk(clk), .rst(rst), .sin(sin), .en(en), .start(start), .pready(pready),
        .pout(pout), .pvalid(pvalid), .busy(busy), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic st);
        sin   = b;
        en    = 1'b1;
        start = st;
        tick();
        en    = 1'b0;
        start = 1'b0;
    endtask

    task automatic send_frame(input logic [3:0] w);
        for (int i = 3; i >= 0; i--) send_bit(w[i], i == 3);
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        #1 rst = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        rst = 1'b0;
        chk("rst_pout", pout, 0);
        chk("rst_pvalid", pvalid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovf", ovf, 0);

        // en without start in IDLE is ignored
        send_bit(1'b1, 1'b0);
        chk("idle_ignore_busy", busy, 0);

        // back-to-back, consumer always ready
        pready = 1'b1;
        send_frame(4'hA);
        chk("b2b_pout_a", pout, 4'hA);
        chk("b2b_pvalid_a", pvalid, 1);
        send_frame(4'h5);
        chk("b2b_pout_5", pout, 4'h5);
        chk("b2b_pvalid_5", pvalid, 1);
        chk("b2b_ovf", ovf, 0);
        pready = 1'b0;

        // reset mid-frame
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b0);
        chk("mid_busy", busy, 1);
        rst = 1'b1;
        #1;
        chk("arst_pout", pout, 0);
        chk("arst_pvalid", pvalid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_ovf", ovf, 0);
        #1 rst = 1'b0;
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b0);
        chk("r9_pvalid_early", pvalid, 0);
        send_bit(1'b1, 1'b0);
        chk("r9_pout", pout, 4'h9);
        chk("r9_pvalid", pvalid, 1);
        chk("r9_busy", busy, 0);
        pready = 1'b1;
        tick();
        pready = 1'b0;
        chk("drain_pvalid", pvalid, 0);
        chk("drain_pout_kept", pout, 4'h9);

        // gapped strobes
        for (int i = 3; i >= 0; i--) begin
            send_bit(4'hD >> i, i == 3);
            if (i != 0) begin
                for (int g = 0; g < 3; g++) begin
                    tick();
                    chk("gap_busy", busy, 1);
                    chk("gap_pvalid", pvalid, 0);
                end
            end
        end
        chk("gap_pout", pout, 4'hD);
        chk("gap_pvalid_set", pvalid, 1);
        chk("gap_busy_done", busy, 0);
        tick();
        tick();
        chk("hold_pvalid", pvalid, 1);
        chk("hold_pout", pout, 4'hD);
        pready = 1'b1;
        tick();
        tick();
        pready = 1'b0;
        chk("gap_single_pulse", pvalid, 0);

        // backpressure overrun
        send_frame(4'h3);
        chk("ovr_pout_3", pout, 4'h3);
        chk("ovr_ovf_pre", ovf, 0);
        send_frame(4'hC);
        chk("ovr_pout_kept", pout, 4'h3);
        chk("ovr_pvalid", pvalid, 1);
        chk("ovr_ovf", ovf, 1);
        pready = 1'b1;
        tick();
        pready = 1'b0;
        chk("ovr_drain_pvalid", pvalid, 0);
        chk("ovr_sticky", ovf, 1);
        tick();
        chk("ovr_sticky2", ovf, 1);

        // drain on completion edge
        do_reset();
        send_frame(4'h6);
        chk("dc_pout_6", pout, 4'h6);
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b0);
        chk("dc_pout_hold", pout, 4'h6);
        pready = 1'b1;
        send_bit(1'b1, 1'b0);
        pready = 1'b0;
        chk("dc_pout_9", pout, 4'h9);
        chk("dc_pvalid", pvalid, 1);
        chk("dc_ovf", ovf, 0);
        pready = 1'b1;
        tick();
        pready = 1'b0;

        // resync after two bits
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b1);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        chk("rs_pvalid_early", pvalid, 0);
        chk("rs_busy", busy, 1);
        send_bit(1'b0, 1'b0);
        chk("rs_pout", pout, 4'h6);
        chk("rs_pvalid", pvalid, 1);
        chk("rs_ovf", ovf, 0);
        pready = 1'b1;
        tick();

        // resync where completion would otherwise have happened
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b1);
        chk("rs2_pvalid_none", pvalid, 0);
        chk("rs2_busy", busy, 1);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        chk("rs2_pout", pout, 4'hB);
        chk("rs2_pvalid", pvalid, 1);
        tick();
        chk("rs2_consumed", pvalid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
